rectangle128_core: RTL and testbench

Datapath and control for RECTANGLE-128 encryption and decryption of one 64-bit block. It is the read-side client of the subkey memory: it drives RAddr and consumes KeyOut, gated by skey_ready, once the key schedule generator has filled the 26 subkeys. It is iterative, one round per clock, and is instantiated beside the subkey memory in the cipher top.

---
 rtl/rectangle128_core.sv | 277 +++++++++++++++++++++++++++
 tb/tb_rectangle128_core.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rectangle128_core.sv
// -----------------------------------------------------------------------------
// rectangle128_core
// Iterative RECTANGLE-128 encrypt/decrypt datapath for one 64-bit block, one
// round per clock. Reads round subkeys from an external subkey memory with a
// one-clock read latency.
//
// Ports:
//   Clk          rising-edge clock
//   RstN         asynchronous active-low reset
//   Start        request; sampled only when idle (IDLE or DONE)
//   Encrypt      1 = encrypt, 0 = decrypt; latched with Start
//   plainText    input block (ciphertext when decrypting); latched with Start
//   skey_ready   subkey memory holds a complete schedule; gates start, aborts
//   RAddr        subkey read index presented to the memory
//   KeyOut       subkey data, valid one clock after RAddr
//   cipherText   result block, held until the next result
//   cipherReady  result valid level, cleared when the next Start is accepted
//   Busy         operation in progress
//
// Row mapping: row0=[15:0], row1=[31:16], row2=[47:32], row3=[63:48].
// -----------------------------------------------------------------------------
module rectangle128_core #(
    parameter int NROUNDS    = 25,
    parameter int MEM_RD_LAT = 1
) (
    input  logic        Clk,
    input  logic        RstN,
    input  logic        Start,
    input  logic        Encrypt,
    input  logic [63:0] plainText,
    input  logic        skey_ready,
    output logic [4:0]  RAddr,
    input  logic [63:0] KeyOut,
    output logic [63:0] cipherText,
    output logic        cipherReady,
    output logic        Busy
);

    // Counter must reach NROUNDS+1: rounds 0..NROUNDS plus one write-back slot.
    localparam int            CW       = $clog2(NROUNDS + 2);
    localparam logic [CW-1:0] LAST_C   = CW'(NROUNDS);
    localparam logic [CW-1:0] WB_C     = CW'(NROUNDS + 1);
    localparam logic [4:0]    LAST_IDX = 5'(NROUNDS);

    if (MEM_RD_LAT != 1) begin : g_bad_rd_lat
        $error("rectangle128_core: MEM_RD_LAT must be 1");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRIME = 2'd1,
        S_ROUND = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [63:0]   data_q, data_d;
    logic          enc_q, enc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    raddr_q, raddr_d;
    logic [63:0]   ctext_q, ctext_d;
    logic          crdy_q, crdy_d;
    logic          busy_q, busy_d;

    logic          accept_s;
    logic [4:0]    raddr_step_s;
    logic [63:0]   key_mix_s;
    logic [63:0]   round_s;

    // ---------------------------------------------------------------- helpers
    function automatic logic [3:0] sbox(input logic [3:0] x);
        case (x)
            4'h0: sbox = 4'h6;  4'h1: sbox = 4'h5;  4'h2: sbox = 4'hC;  4'h3: sbox = 4'hA;
            4'h4: sbox = 4'h1;  4'h5: sbox = 4'hE;  4'h6: sbox = 4'h7;  4'h7: sbox = 4'h9;
            4'h8: sbox = 4'hB;  4'h9: sbox = 4'h0;  4'hA: sbox = 4'h3;  4'hB: sbox = 4'hD;
            4'hC: sbox = 4'h8;  4'hD: sbox = 4'hF;  4'hE: sbox = 4'h4;  4'hF: sbox = 4'h2;
            default: sbox = 4'h0;
        endcase
    endfunction

    function automatic logic [3:0] inv_sbox(input logic [3:0] x);
        case (x)
            4'h0: inv_sbox = 4'h9;  4'h1: inv_sbox = 4'h4;  4'h2: inv_sbox = 4'hF;  4'h3: inv_sbox = 4'hA;
            4'h4: inv_sbox = 4'hE;  4'h5: inv_sbox = 4'h1;  4'h6: inv_sbox = 4'h0;  4'h7: inv_sbox = 4'h6;
            4'h8: inv_sbox = 4'hC;  4'h9: inv_sbox = 4'h7;  4'hA: inv_sbox = 4'h3;  4'hB: inv_sbox = 4'h8;
            4'hC: inv_sbox = 4'h2;  4'hD: inv_sbox = 4'hB;  4'hE: inv_sbox = 4'h5;  4'hF: inv_sbox = 4'hD;
            default: inv_sbox = 4'h0;
        endcase
    endfunction

    // Column j is the nibble {row3[j],row2[j],row1[j],row0[j]}, row0 as LSB.
    function automatic logic [63:0] sub_column(input logic [63:0] d, input logic inv);
        logic [3:0]  nib;
        logic [3:0]  sub;
        logic [63:0] r;
        r = 64'h0;
        for (int j = 0; j < 16; j++) begin
            nib = {d[48+j], d[32+j], d[16+j], d[j]};
            if (inv) begin
                sub = inv_sbox(nib);
            end else begin
                sub = sbox(nib);
            end
            r[j]    = sub[0];
            r[16+j] = sub[1];
            r[32+j] = sub[2];
            r[48+j] = sub[3];
        end
        return r;
    endfunction

    // Forward: row1 rotl 1, row2 rotl 12, row3 rotl 13; inverse rotates right.
    function automatic logic [63:0] shift_row(input logic [63:0] d, input logic inv);
        logic [15:0] r1;
        logic [15:0] r2;
        logic [15:0] r3;
        r1 = d[31:16];
        r2 = d[47:32];
        r3 = d[63:48];
        if (inv) begin
            return {{r3[12:0], r3[15:13]}, {r2[11:0], r2[15:12]}, {r1[0], r1[15:1]}, d[15:0]};
        end else begin
            return {{r3[2:0], r3[15:3]}, {r2[3:0], r2[15:4]}, {r1[14:0], r1[15]}, d[15:0]};
        end
    endfunction

    // State and datapath registers.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state_q <= S_IDLE;
            data_q  <= 64'h0;
            enc_q   <= 1'b0;
            cnt_q   <= {CW{1'b0}};
            raddr_q <= 5'd0;
            ctext_q <= 64'h0;
            crdy_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            enc_q   <= enc_d;
            cnt_q   <= cnt_d;
            raddr_q <= raddr_d;
            ctext_q <= ctext_d;
            crdy_q  <= crdy_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic; losing skey_ready while working abandons the block.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (Start && skey_ready) begin
                    state_d = S_PRIME;
                end else begin
                    state_d = state_q;
                end
            end
            S_PRIME: begin
                if (!skey_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                if (!skey_ready) begin
                    state_d = S_IDLE;
                end else if (cnt_q == WB_C) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_ROUND;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // One round of the cipher selected by direction and round index.
    always_comb begin
        key_mix_s = data_q ^ KeyOut;
        if (enc_q) begin
            if (cnt_q == LAST_C) begin
                round_s = key_mix_s;
            end else begin
                round_s = shift_row(sub_column(key_mix_s, 1'b0), 1'b0);
            end
        end else begin
            if (cnt_q == {CW{1'b0}}) begin
                round_s = key_mix_s;
            end else begin
                round_s = sub_column(shift_row(data_q, 1'b1), 1'b1) ^ KeyOut;
            end
        end
    end

    // Subkey index walks toward the far end of the schedule and sticks there.
    always_comb begin
        if (enc_q) begin
            if (raddr_q == LAST_IDX) begin
                raddr_step_s = raddr_q;
            end else begin
                raddr_step_s = raddr_q + 5'd1;
            end
        end else begin
            if (raddr_q == 5'd0) begin
                raddr_step_s = raddr_q;
            end else begin
                raddr_step_s = raddr_q - 5'd1;
            end
        end
    end

    // Output / datapath register updates for each state.
    always_comb begin
        data_d   = data_q;
        enc_d    = enc_q;
        cnt_d    = cnt_q;
        raddr_d  = raddr_q;
        ctext_d  = ctext_q;
        crdy_d   = crdy_q;
        busy_d   = busy_q;
        accept_s = Start && skey_ready;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept_s) begin
                    data_d  = plainText;
                    enc_d   = Encrypt;
                    raddr_d = Encrypt ? 5'd0 : LAST_IDX;
                    cnt_d   = {CW{1'b0}};
                    crdy_d  = 1'b0;
                    busy_d  = 1'b1;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            S_PRIME: begin
                if (!skey_ready) begin
                    busy_d = 1'b0;
                    crdy_d = 1'b0;
                end else begin
                    raddr_d = raddr_step_s;
                    cnt_d   = {CW{1'b0}};
                end
            end
            S_ROUND: begin
                if (!skey_ready) begin
                    busy_d = 1'b0;
                    crdy_d = 1'b0;
                end else begin
                    raddr_d = raddr_step_s;
                    cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    if (cnt_q == WB_C) begin
                        // Write-back slot: publish the finished block.
                        ctext_d = data_q;
                        crdy_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        data_d  = round_s;
                    end
                end
            end
            default: begin
                busy_d = 1'b0;
                crdy_d = 1'b0;
            end
        endcase
    end

    assign RAddr       = raddr_q;
    assign cipherText  = ctext_q;
    assign cipherReady = crdy_q;
    assign Busy        = busy_q;

endmodule

// File: tb/tb_rectangle128_core.sv
// -----------------------------------------------------------------------------
// tb_rectangle128_core
// Self-checking bench for rectangle128_core. A behavioural RECTANGLE model
// (integer rotations and table lookups on rows/columns) provides expected
// blocks; a registered memory model supplies subkeys one clock after RAddr.
// -----------------------------------------------------------------------------
module tb_rectangle128_core;

    logic        Clk;
    logic        RstN;
    logic        Start;
    logic        Encrypt;
    logic [63:0] plainText;
    logic        skey_ready;
    logic [4:0]  RAddr;
    logic [63:0] KeyOut;
    logic [63:0] cipherText;
    logic        cipherReady;
    logic        Busy;

    logic [63:0] mem [32];
    int          raddr_log [64];
    int          checks   = 0;
    int          failures = 0;
    logic [63:0] last_result;

    localparam logic [63:0] PT0 = 64'h0123456789ABCDEF;

    int SBOX     [16] = '{6, 5, 12, 10, 1, 14, 7, 9, 11, 0, 3, 13, 8, 15, 4, 2};
    int INV_SBOX [16] = '{9, 4, 15, 10, 14, 1, 0, 6, 12, 7, 3, 8, 2, 11, 5, 13};
    int ROT      [4]  = '{0, 1, 12, 13};

    rectangle128_core #(.NROUNDS(25), .MEM_RD_LAT(1)) dut (
        .Clk        (Clk),
        .RstN       (RstN),
        .Start      (Start),
        .Encrypt    (Encrypt),
        .plainText  (plainText),
        .skey_ready (skey_ready),
        .RAddr      (RAddr),
        .KeyOut     (KeyOut),
        .cipherText (cipherText),
        .cipherReady(cipherReady),
        .Busy       (Busy)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Subkey memory with one clock of read latency.
    always @(posedge Clk) KeyOut <= mem[RAddr];

    // ------------------------------------------------------------ model
    function automatic logic [63:0] m_sub(input logic [63:0] d, input bit inv);
        logic [63:0] r;
        int n;
        int s;
        r = 64'd0;
        for (int j = 0; j < 16; j++) begin
            n = 0;
            for (int row = 0; row < 4; row++)
                n = n + (int'((d >> (16 * row + j)) & 64'd1) << row);
            s = inv ? INV_SBOX[n] : SBOX[n];
            for (int row = 0; row < 4; row++)
                if (((s >> row) & 1) == 1) r = r | (64'd1 << (16 * row + j));
        end
        return r;
    endfunction

    function automatic logic [63:0] m_shift(input logic [63:0] d, input bit inv);
        logic [63:0] r;
        int x;
        int a;
        int y;
        r = 64'd0;
        for (int i = 0; i < 4; i++) begin
            x = int'((d >> (16 * i)) & 64'hFFFF);
            a = inv ? (16 - ROT[i]) % 16 : ROT[i];
            y = ((x << a) | (x >> (16 - a))) & 32'hFFFF;
            r = r | (64'(y) << (16 * i));
        end
        return r;
    endfunction

    function automatic logic [63:0] m_enc(input logic [63:0] p);
        logic [63:0] d;
        d = p;
        for (int r = 0; r < 25; r++) d = m_shift(m_sub(d ^ mem[r], 1'b0), 1'b0);
        return d ^ mem[25];
    endfunction

    function automatic logic [63:0] m_dec(input logic [63:0] c);
        logic [63:0] d;
        d = c ^ mem[25];
        for (int r = 24; r >= 0; r--) d = m_sub(m_shift(d, 1'b1), 1'b1) ^ mem[r];
        return d;
    endfunction

    // ------------------------------------------------------------ helpers
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic load_keys();
        for (int i = 0; i < 32; i++) mem[i] = {$urandom, $urandom};
    endtask

    // Ticks until cipherReady; lat is the edge count since the Start edge, -1 on timeout.
    task automatic wait_done(input int start_n, output int lat);
        lat = -1;
        for (int n = start_n + 1; n <= start_n + 60; n++) begin
            tick();
            if (n < 64) raddr_log[n] = int'(RAddr);
            if (cipherReady === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic run_op(input logic [63:0] pt, input bit enc,
                          output logic [63:0] res, output int lat);
        plainText = pt;
        Encrypt   = enc;
        Start     = 1'b1;
        tick();
        raddr_log[0] = int'(RAddr);
        Start = 1'b0;
        wait_done(0, lat);
        res = cipherText;
    endtask

    // ------------------------------------------------------------ tests
    task automatic test_reset();
        RstN = 1'b1;
        #2 RstN = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        checks++; if (RAddr !== 5'd0) begin failures++; $display("FAIL reset_raddr: got %0d expected 0", RAddr); end
        checks++; if (cipherText !== 64'd0) begin failures++; $display("FAIL reset_ctext: got %h expected 0", cipherText); end
        checks++; if (cipherReady !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b expected 0", cipherReady); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", Busy); end
        @(negedge Clk);
        RstN = 1'b1;
        tick();
    endtask

    task automatic test_encrypt();
        logic [63:0] res;
        logic [63:0] exp;
        int lat;
        exp = m_enc(PT0);
        run_op(PT0, 1'b1, res, lat);
        checks++; if (lat !== 28) begin failures++; $display("FAIL enc_latency: got %0d expected 28", lat); end
        checks++; if (res !== exp) begin failures++; $display("FAIL enc_result: got %h expected %h", res, exp); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL enc_busy_done: got %b expected 0", Busy); end
        for (int i = 0; i < 26; i++) begin
            checks++;
            if (raddr_log[i] !== i) begin failures++; $display("FAIL enc_raddr[%0d]: got %0d expected %0d", i, raddr_log[i], i); end
        end
        last_result = exp;
    endtask

    task automatic test_decrypt();
        logic [63:0] res;
        int lat;
        run_op(m_enc(PT0), 1'b0, res, lat);
        checks++; if (lat !== 28) begin failures++; $display("FAIL dec_latency: got %0d expected 28", lat); end
        checks++; if (res !== PT0) begin failures++; $display("FAIL dec_result: got %h expected %h", res, PT0); end
        for (int i = 0; i < 26; i++) begin
            checks++;
            if (raddr_log[i] !== 25 - i) begin failures++; $display("FAIL dec_raddr[%0d]: got %0d expected %0d", i, raddr_log[i], 25 - i); end
        end
        last_result = PT0;
    endtask

    task automatic test_skey_gate();
        logic [63:0] pt;
        int lat;
        int bad;
        pt = {$urandom, $urandom};
        skey_ready = 1'b0;
        plainText  = pt;
        Encrypt    = 1'b1;
        Start      = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (Busy !== 1'b0 || cipherReady !== 1'b1 || cipherText !== last_result) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL gate_idle_cycles: got %0d active cycles expected 0", bad); end
        skey_ready = 1'b1;
        tick();
        checks++; if (Busy !== 1'b1) begin failures++; $display("FAIL gate_start_busy: got %b expected 1", Busy); end
        checks++; if (cipherReady !== 1'b0) begin failures++; $display("FAIL gate_start_ready: got %b expected 0", cipherReady); end
        Start = 1'b0;
        wait_done(0, lat);
        checks++; if (lat !== 28) begin failures++; $display("FAIL gate_latency: got %0d expected 28", lat); end
        checks++; if (cipherText !== m_enc(pt)) begin failures++; $display("FAIL gate_result: got %h expected %h", cipherText, m_enc(pt)); end
        last_result = m_enc(pt);
    endtask

    task automatic test_abort();
        logic [63:0] pt;
        logic [63:0] res;
        int lat;
        int bad;
        pt = {$urandom, $urandom};
        plainText = pt;
        Encrypt   = 1'b1;
        Start     = 1'b1;
        tick();
        Start = 1'b0;
        repeat (11) tick();
        skey_ready = 1'b0;
        tick();
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b expected 0", Busy); end
        checks++; if (cipherReady !== 1'b0) begin failures++; $display("FAIL abort_ready: got %b expected 0", cipherReady); end
        checks++; if (cipherText !== last_result) begin failures++; $display("FAIL abort_ctext: got %h expected %h", cipherText, last_result); end
        skey_ready = 1'b1;
        bad = 0;
        for (int i = 0; i < 35; i++) begin
            tick();
            if (Busy !== 1'b0 || cipherReady !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL abort_stays_idle: got %0d active cycles expected 0", bad); end
        pt = {$urandom, $urandom};
        run_op(pt, 1'b1, res, lat);
        checks++; if (lat !== 28) begin failures++; $display("FAIL abort_restart_latency: got %0d expected 28", lat); end
        checks++; if (res !== m_enc(pt)) begin failures++; $display("FAIL abort_restart_result: got %h expected %h", res, m_enc(pt)); end
        last_result = res;
    endtask

    task automatic test_start_ignored();
        logic [63:0] pa;
        int lat;
        pa = {$urandom, $urandom};
        plainText = pa;
        Encrypt   = 1'b1;
        Start     = 1'b1;
        tick();
        Start = 1'b0;
        repeat (5) tick();
        plainText = ~pa;
        Encrypt   = 1'b0;
        Start     = 1'b1;
        tick();
        Start = 1'b0;
        wait_done(6, lat);
        checks++; if (lat !== 28) begin failures++; $display("FAIL busy_start_latency: got %0d expected 28", lat); end
        checks++; if (cipherText !== m_enc(pa)) begin failures++; $display("FAIL busy_start_result: got %h expected %h", cipherText, m_enc(pa)); end
        last_result = m_enc(pa);
    endtask

    task automatic test_async_reset();
        logic [63:0] pt;
        logic [63:0] ct;
        logic [63:0] back;
        int lat;
        int lat2;
        int bad;
        pt = {$urandom, $urandom};
        plainText = pt;
        Encrypt   = 1'b1;
        Start     = 1'b1;
        tick();
        Start = 1'b0;
        repeat (6) tick();
        #2 RstN = 1'b0;
        #1;
        checks++; if (RAddr !== 5'd0) begin failures++; $display("FAIL arst_raddr: got %0d expected 0", RAddr); end
        checks++; if (cipherText !== 64'd0) begin failures++; $display("FAIL arst_ctext: got %h expected 0", cipherText); end
        checks++; if (cipherReady !== 1'b0) begin failures++; $display("FAIL arst_ready: got %b expected 0", cipherReady); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL arst_busy: got %b expected 0", Busy); end
        @(negedge Clk);
        RstN = 1'b1;
        tick();
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            if (i % 100 == 0) load_keys();
            pt = {$urandom, $urandom};
            run_op(pt, 1'b1, ct, lat);
            run_op(ct, 1'b0, back, lat2);
            checks++;
            if (ct !== m_enc(pt)) begin failures++; $display("FAIL b2b_enc[%0d]: got %h expected %h", i, ct, m_enc(pt)); end
            checks++;
            if (back !== pt) begin failures++; $display("FAIL b2b_dec[%0d]: got %h expected %h", i, back, pt); end
            checks++;
            if (m_dec(ct) !== pt) begin failures++; $display("FAIL b2b_model_inv[%0d]: got %h expected %h", i, m_dec(ct), pt); end
            if (lat != 28 || lat2 != 28) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL b2b_latency: got %0d late blocks expected 0", bad); end
    endtask

    initial begin
        RstN       = 1'b1;
        Start      = 1'b0;
        Encrypt    = 1'b0;
        plainText  = 64'd0;
        skey_ready = 1'b1;
        load_keys();
        test_reset();
        test_encrypt();
        test_decrypt();
        test_skey_gate();
        test_abort();
        test_start_ignored();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
